// File: rtl/mem_image_loader_if.sv
// rtl/mem_image_loader_if.sv - byte stream in / memory write port out bundle for mem_image_loader
interface mem_image_loader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) ();
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // master: the loader (consumes bytes, drives the memory write port)
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  // slave: the environment (byte source, memory)
  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_image_loader.sv
// rtl/mem_image_loader.sv - streams a big-endian byte image into memory from word 0, holding the CPU in reset
// Optional trailer checksum check enabled by defining CHECKSUM_EN.
module mem_image_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] load_len,
  mem_image_loader_if.master  bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                csum_err
);

  localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CSUM, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;
`endif

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  // Holds the first three bytes of a word; the fourth byte completes it directly
  logic [DATA_WIDTH-9:0] part_q, part_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic [ADDR_WIDTH:0]   len_clamped;
  logic [DATA_WIDTH-1:0] assembled;
`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  csum_err_q, csum_err_d;
`endif

  assign len_clamped = (load_len > MaxLen) ? MaxLen : load_len;
  assign assembled   = {part_q, bus.byte_data};

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    word_idx_d     = word_idx_q;
    len_d          = len_q;
    part_d         = part_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
`ifdef CHECKSUM_EN
    sum_d          = sum_q;
    csum_err_d     = csum_err_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          len_d      = len_clamped;
          word_idx_d = '0;
          byte_cnt_d = '0;
`ifdef CHECKSUM_EN
          sum_d      = '0;
          csum_err_d = 1'b0;
`endif
          state_d    = (len_clamped == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (bus.byte_valid) begin
          part_d     = assembled[DATA_WIDTH-9:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            addr_d  = word_idx_q[ADDR_WIDTH-1:0];
            wdata_d = assembled;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
        byte_cnt_d = '0;
`ifdef CHECKSUM_EN
        sum_d      = sum_q + wdata_q;
        state_d    = (word_idx_q + 1'b1 == len_q) ? CSUM : RECV;
`else
        state_d    = (word_idx_q + 1'b1 == len_q) ? DONE : RECV;
`endif
      end
`ifdef CHECKSUM_EN
      CSUM: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (bus.byte_valid) begin
          part_d     = assembled[DATA_WIDTH-9:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            csum_err_d = (assembled != sum_q);
            state_d    = DONE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // The CPU runs only from a clean DONE; a checksum mismatch keeps it held
`ifdef CHECKSUM_EN
    cpu_reset_d = (state_d != DONE) || csum_err_d;
`else
    cpu_reset_d = (state_d != DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      len_q       <= '0;
      part_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
`ifdef CHECKSUM_EN
      sum_q       <= '0;
      csum_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      len_q       <= len_d;
      part_q      <= part_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef CHECKSUM_EN
      sum_q       <= sum_d;
      csum_err_q  <= csum_err_d;
`endif
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_reset     = cpu_reset_q;
`ifdef CHECKSUM_EN
  assign csum_err      = csum_err_q;
`else
  assign csum_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_image_loader.sv
// tb/tb_mem_image_loader.sv - directed self-checking bench for mem_image_loader
module tb_mem_image_loader;
  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [AW:0] load_len = '0;
  logic        cpu_reset, busy, done, csum_err;

  mem_image_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  mem_image_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_len (load_len),
    .bus      (bus),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .csum_err (csum_err)
  );

  always #5 clk = ~clk;

  int          vecs = 0;
  int          miscompares = 0;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [31:0] mem_img[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vecs++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Write-port monitor: logs every write and checks the stream is stalled during it
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      chk("ready_in_write", {31'd0, bus.byte_ready}, 32'd0);
      wlog_addr.push_back({26'd0, bus.mem_addr});
      wlog_data.push_back(bus.mem_wdata);
      mem_img[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // All tasks start and end at posedge+1
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    bus.byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.byte_ready;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
    if (!ok) timeout("byte_accept");
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 3; i >= 0; i--)
      send_byte(w[i*8 +: 8], rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic start_load(input logic [AW:0] len);
    start    = 1'b1;
    load_len = len;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) timeout("wait_done");
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[64];
    logic [31:0] sum;
    int          errs;

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    for (int i = 0; i < 64; i++) mem_img[i] = 32'h0;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("rst_mem_addr",   {26'd0, bus.mem_addr},   32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,           32'd0);
    chk("rst_cpu_reset",  {31'd0, cpu_reset},      32'd1);
    chk("rst_busy",       {31'd0, busy},           32'd0);
    chk("rst_done",       {31'd0, done},           32'd0);
    chk("rst_csum_err",   {31'd0, csum_err},       32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 2: two words back-to-back
    start_load(7'd2);
    send_word(32'h12345678, 1'b0);
    send_word(32'hAABBCCDD, 1'b0);
`ifdef CHECKSUM_EN
    send_word(32'h12345678 + 32'hAABBCCDD, 1'b0);
`endif
    wait_done(50);
    chk("t2_wr_count", wlog_addr.size(), 32'd2);
    if (wlog_addr.size() == 2) begin
      chk("t2_addr0", wlog_addr[0], 32'd0);
      chk("t2_data0", wlog_data[0], 32'h12345678);
      chk("t2_addr1", wlog_addr[1], 32'd1);
      chk("t2_data1", wlog_data[1], 32'hAABBCCDD);
    end
    chk("t2_done",      {31'd0, done},      32'd1);
    chk("t2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("t2_busy",      {31'd0, busy},      32'd0);
    chk("t2_csum_err",  {31'd0, csum_err},  32'd0);
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (mem_img[i] !== ((i == 0) ? 32'h12345678 : (i == 1) ? 32'hAABBCCDD : 32'h0)) errs++;
    chk("t2_mem_dump_errs", errs, 32'd0);

    // 3: restart from DONE, random valid gaps, a byte held across WRITE
    wlog_addr.delete();
    wlog_data.delete();
    start_load(7'd2);
    @(negedge clk);
    chk("t3_restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("t3_restart_done",      {31'd0, done},      32'd0);
    chk("t3_restart_busy",      {31'd0, busy},      32'd1);
    @(posedge clk); #1;
    send_word(32'h12345678, 1'b1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 2);
    send_byte(8'hCC, 1);
    send_byte(8'hDD, 0);
`ifdef CHECKSUM_EN
    send_word(32'h12345678 + 32'hAABBCCDD, 1'b1);
`endif
    wait_done(80);
    chk("t3_wr_count", wlog_addr.size(), 32'd2);
    if (wlog_addr.size() == 2) begin
      chk("t3_addr0", wlog_addr[0], 32'd0);
      chk("t3_data0", wlog_data[0], 32'h12345678);
      chk("t3_addr1", wlog_addr[1], 32'd1);
      chk("t3_data1", wlog_data[1], 32'hAABBCCDD);
    end

    // 4a: zero-length image
    pulse_reset();
    wlog_addr.delete();
    wlog_data.delete();
    start_load(7'd0);
    @(negedge clk);
    chk("t4_len0_done",      {31'd0, done},      32'd1);
    chk("t4_len0_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    chk("t4_len0_writes", wlog_addr.size(), 32'd0);

    // 4b: oversized length clamps to a full 64-word memory
    sum = 32'h0;
    for (int i = 0; i < 64; i++) begin
      w[i] = {8'(i), 8'h5A, ~8'(i), 8'(i + 1)};
      sum  = sum + w[i];
    end
    start_load(7'd100);
    for (int i = 0; i < 64; i++) send_word(w[i], 1'b0);
`ifdef CHECKSUM_EN
    send_word(sum, 1'b0);
`endif
    wait_done(50);
    chk("t4_full_count", wlog_addr.size(), 32'd64);
    errs = 0;
    for (int i = 0; i < 64 && i < wlog_addr.size(); i++)
      if (wlog_addr[i] !== 32'(i) || wlog_data[i] !== w[i]) errs++;
    chk("t4_full_entry_errs", errs, 32'd0);
    chk("t4_full_last_addr",  {26'd0, bus.mem_addr}, 32'd63);
    chk("t4_full_done",       {31'd0, done},         32'd1);
    chk("t4_full_csum_err",   {31'd0, csum_err},     32'd0);

    // 5: reset mid-word discards the partial word
    start_load(7'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_reset();
    @(negedge clk);
    chk("t5_abort_busy",       {31'd0, busy},           32'd0);
    chk("t5_abort_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("t5_abort_cpu_reset",  {31'd0, cpu_reset},      32'd1);
    @(posedge clk); #1;
    wlog_addr.delete();
    wlog_data.delete();
    start_load(7'd1);
    send_word(32'hDEADBEEF, 1'b0);
`ifdef CHECKSUM_EN
    send_word(32'hDEADBEEF, 1'b0);
`endif
    wait_done(50);
    chk("t5_wr_count", wlog_addr.size(), 32'd1);
    if (wlog_addr.size() == 1) begin
      chk("t5_addr0", wlog_addr[0], 32'd0);
      chk("t5_data0", wlog_data[0], 32'hDEADBEEF);
    end
    chk("t5_cpu_reset", {31'd0, cpu_reset}, 32'd0);

`ifdef CHECKSUM_EN
    // 6: checksum trailer match and mismatch
    start_load(7'd2);
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00000003, 1'b0);
    wait_done(50);
    chk("t6_ok_csum_err",  {31'd0, csum_err},  32'd0);
    chk("t6_ok_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    start_load(7'd2);
    send_word(32'h00000001, 1'b0);
    send_word(32'h00000002, 1'b0);
    send_word(32'h00000004, 1'b0);
    wait_done(50);
    chk("t6_bad_csum_err",  {31'd0, csum_err},  32'd1);
    chk("t6_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("t6_bad_done",      {31'd0, done},      32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
